// File: rtl/zap_dmem_pkg.sv
// Shared types and constants for the ZAP data-memory wait-state controller.
// ZAP_DMEM_ALIGN_ABORT_EN (see zap_dmem_wait_ctrl) makes misaligned accesses abort.
package zap_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } dmem_state_t;

  localparam int CNT_W = 4;

  // Abort reasons, kept for debug visibility only
  localparam logic [1:0] ABT_NONE  = 2'd0;
  localparam logic [1:0] ABT_RANGE = 2'd1;
  localparam logic [1:0] ABT_ALIGN = 2'd2;

  function automatic logic misaligned(input logic [3:0] ben, input logic [1:0] a);
    return ((ben == 4'hF) && (a != 2'b00)) ||
           (((ben == 4'h3) || (ben == 4'hC)) && a[0]);
  endfunction

endpackage

// File: rtl/zap_dmem_wait_counter.sv
// 4-bit loadable down-counter that counts SRAM wait states; saturates at zero.
module zap_dmem_wait_counter
  import zap_dmem_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                    r_cnt <= '0;
    else if (i_load)                   r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/zap_dmem_wait_ctrl.sv
// Data-side SRAM controller for the ZAP core: inserts WAIT_STATES cycles before each access.
// Define ZAP_DMEM_ALIGN_ABORT_EN to abort misaligned word/halfword accesses.
module zap_dmem_wait_ctrl
  import zap_dmem_pkg::*;
#(
  parameter int SIZE_IN_BYTES = 1024,
  parameter int WAIT_STATES   = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_read_en,
  input  logic                             i_write_en,
  input  logic [31:0]                      i_address,
  input  logic [3:0]                       i_ben,
  input  logic [31:0]                      i_wr_data,
  output logic [31:0]                      o_rd_data,
  output logic                             o_data_stall,
  output logic                             o_data_abort,
  output logic                             o_sram_en,
  output logic                             o_sram_we,
  output logic [3:0]                       o_sram_ben,
  output logic [$clog2(SIZE_IN_BYTES/4)-1:0] o_sram_addr,
  output logic [31:0]                      o_sram_wdata,
  input  logic [31:0]                      i_sram_rdata
);

  localparam int AW = $clog2(SIZE_IN_BYTES/4);
  localparam logic [CNT_W-1:0] LOAD_VAL = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  dmem_state_t r_state, w_state_nxt;
  logic        r_abort, r_rd_op;
  logic [31:0] r_rd_data;
  logic        w_req, w_range_err, w_align_err, w_abort;
  logic [1:0]  w_abort_why;
  logic        w_cnt_load, w_cnt_en, w_cnt_zero;
  logic        w_access, w_rd_done;

  assign w_req       = i_read_en | i_write_en;
  assign w_range_err = (i_address >= 32'(SIZE_IN_BYTES));

`ifdef ZAP_DMEM_ALIGN_ABORT_EN
  assign w_align_err = misaligned(i_ben, i_address[1:0]);
`else
  assign w_align_err = 1'b0;
`endif

  assign w_abort_why = w_range_err ? ABT_RANGE : (w_align_err ? ABT_ALIGN : ABT_NONE);
  assign w_abort     = (w_abort_why != ABT_NONE);

  zap_dmem_wait_counter u_cnt (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_abort)               w_state_nxt = ST_DONE;
          else if (WAIT_STATES == 0) w_state_nxt = ST_ACCESS;
          else begin
            w_state_nxt = ST_WAIT;
            w_cnt_load  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A dropped request (core flush) abandons the access before the SRAM sees it
        if (!w_req)          w_state_nxt = ST_IDLE;
        else if (w_cnt_zero) w_state_nxt = ST_ACCESS;
        else                 w_cnt_en    = 1'b1;
      end
      ST_ACCESS: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_abort   <= 1'b0;
      r_rd_op   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE)   r_abort <= w_req & w_abort;
      if (r_state == ST_ACCESS) r_rd_op <= ~i_write_en;
      if (w_rd_done)            r_rd_data <= i_sram_rdata;
    end
  end

  assign w_access  = (r_state == ST_ACCESS);
  assign w_rd_done = (r_state == ST_DONE) & r_rd_op & ~r_abort;

  assign o_sram_en    = w_access;
  assign o_sram_we    = w_access & i_write_en;
  assign o_sram_ben   = w_access ? i_ben : 4'h0;
  assign o_sram_addr  = w_access ? i_address[AW+1:2] : '0;
  assign o_sram_wdata = w_access ? i_wr_data : 32'h0;

  // SRAM data arrives in DONE; bypass it so the core sees it that cycle, then hold it
  assign o_rd_data    = w_rd_done ? i_sram_rdata : r_rd_data;
  assign o_data_abort = (r_state == ST_DONE) & r_abort;
  assign o_data_stall = w_req & (r_state != ST_DONE);

endmodule

// File: tb/tb_zap_dmem_wait_ctrl.sv
// Scoreboard bench: instance 1 has 2 wait states, instance 0 has none; both share clock/reset.
module tb_zap_dmem_wait_ctrl;

  typedef struct { int k; logic abort; logic [31:0] rd; int stalls; } cmp_t;
  typedef struct { int k; logic we; logic [7:0] addr; logic [3:0] ben; logic [31:0] wd; } stb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rd_en [2], wr_en [2], stall [2], abort [2], sram_en [2], sram_we [2];
  logic [31:0] addr [2], wdata [2], rd_data [2], sram_wd [2], sram_rd [2];
  logic [3:0]  ben [2], sram_ben [2];
  logic [7:0]  sram_addr [2];
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  cmp_t cq[$];
  stb_t sq[$];
  int   n_chk = 0, n_pass = 0;
  int   scnt [2];
  logic [31:0] exp_last;

  zap_dmem_wait_ctrl #(.SIZE_IN_BYTES(1024), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_read_en(rd_en[0]), .i_write_en(wr_en[0]),
    .i_address(addr[0]), .i_ben(ben[0]), .i_wr_data(wdata[0]), .o_rd_data(rd_data[0]),
    .o_data_stall(stall[0]), .o_data_abort(abort[0]), .o_sram_en(sram_en[0]),
    .o_sram_we(sram_we[0]), .o_sram_ben(sram_ben[0]), .o_sram_addr(sram_addr[0]),
    .o_sram_wdata(sram_wd[0]), .i_sram_rdata(sram_rd[0]));

  zap_dmem_wait_ctrl #(.SIZE_IN_BYTES(1024), .WAIT_STATES(2)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_read_en(rd_en[1]), .i_write_en(wr_en[1]),
    .i_address(addr[1]), .i_ben(ben[1]), .i_wr_data(wdata[1]), .o_rd_data(rd_data[1]),
    .o_data_stall(stall[1]), .o_data_abort(abort[1]), .o_sram_en(sram_en[1]),
    .o_sram_we(sram_we[1]), .o_sram_ben(sram_ben[1]), .o_sram_addr(sram_addr[1]),
    .o_sram_wdata(sram_wd[1]), .i_sram_rdata(sram_rd[1]));

  // Synchronous SRAM models: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'h0;
        mem1[i] <= 32'h0;
      end
      mem1[4] <= 32'hDEADBEEF;
    end else begin
      if (sram_en[0]) begin
        if (sram_we[0]) begin
          for (int b = 0; b < 4; b++)
            if (sram_ben[0][b]) mem0[sram_addr[0]][8*b +: 8] <= sram_wd[0][8*b +: 8];
        end else sram_rd[0] <= mem0[sram_addr[0]];
      end
      if (sram_en[1]) begin
        if (sram_we[1]) begin
          for (int b = 0; b < 4; b++)
            if (sram_ben[1][b]) mem1[sram_addr[1]][8*b +: 8] <= sram_wd[1][8*b +: 8];
        end else sram_rd[1] <= mem1[sram_addr[1]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic exp_cmp(input int k, input logic ab, input logic [31:0] rd, input int st);
    cmp_t e;
    e.k = k; e.abort = ab; e.rd = rd; e.stalls = st;
    cq.push_back(e);
  endtask

  task automatic exp_stb(input int k, input logic we, input logic [7:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    stb_t e;
    e.k = k; e.we = we; e.addr = a; e.ben = be; e.wd = wd;
    sq.push_back(e);
  endtask

  // Monitor: completion is a held request with stall low; strobes are popped separately
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   idx;
      cmp_t ce;
      stb_t se;
      if (!rst_n || (!rd_en[k] && !wr_en[k])) scnt[k] = 0;
      else if (stall[k]) scnt[k]++;
      else begin
        idx = -1;
        for (int i = 0; i < cq.size(); i++) if (cq[i].k == k && idx < 0) idx = i;
        if (idx < 0) begin
          n_chk++;
          $display("FAIL unexpected_completion dut%0d: got completion want none", k);
        end else begin
          ce = cq[idx];
          cq.delete(idx);
          chk($sformatf("abort%0d", k), 32'(abort[k]), 32'(ce.abort));
          chk($sformatf("rd_data%0d", k), rd_data[k], ce.rd);
          chk($sformatf("stall_cycles%0d", k), 32'(scnt[k]), 32'(ce.stalls));
        end
        scnt[k] = 0;
      end
      if (rst_n && sram_en[k]) begin
        idx = -1;
        for (int i = 0; i < sq.size(); i++) if (sq[i].k == k && idx < 0) idx = i;
        if (idx < 0) begin
          n_chk++;
          $display("FAIL unexpected_strobe dut%0d: got addr %h want none", k, sram_addr[k]);
        end else begin
          se = sq[idx];
          sq.delete(idx);
          chk($sformatf("sram_we%0d", k), 32'(sram_we[k]), 32'(se.we));
          chk($sformatf("sram_addr%0d", k), 32'(sram_addr[k]), 32'(se.addr));
          chk($sformatf("sram_ben%0d", k), 32'(sram_ben[k]), 32'(se.ben));
          chk($sformatf("sram_wdata%0d", k), sram_wd[k], se.wd);
        end
      end
    end
  end

  task automatic drive(input int k, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    rd_en[k] = rd; wr_en[k] = wr; addr[k] = a; ben[k] = be; wdata[k] = wd;
  endtask

  // Called just after a rising edge; returns just after the edge that ends DONE
  task automatic xact(input int k, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic keep);
    bit done = 0;
    drive(k, rd, wr, a, be, wd);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!stall[k]) done = 1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL timeout dut%0d: got stall stuck want completion", k);
    end
    @(posedge clk); #1;
    if (!keep) drive(k, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      drive(k, 0, 0, 32'h0, 4'h0, 32'h0);
      scnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rd_data%0d", k), rd_data[k], 32'h0);
      chk($sformatf("rst_sram_en%0d", k), 32'(sram_en[k]), 32'h0);
      chk($sformatf("rst_abort%0d", k), 32'(abort[k]), 32'h0);
      chk($sformatf("rst_stall%0d", k), 32'(stall[k]), 32'h0);
    end
    rst_n = 1'b1;
    step(1);

    exp_stb(1, 0, 8'd4, 4'hF, 32'h0); exp_cmp(1, 0, 32'hDEADBEEF, 4);
    xact(1, 1, 0, 32'h10, 4'hF, 32'h0, 0);
    exp_stb(0, 1, 8'd8, 4'hF, 32'hCAFEF00D); exp_cmp(0, 0, 32'h0, 2);
    xact(0, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D, 0);
    exp_stb(0, 0, 8'd8, 4'hF, 32'h0); exp_cmp(0, 0, 32'hCAFEF00D, 2);
    xact(0, 1, 0, 32'h20, 4'hF, 32'h0, 0);
    exp_cmp(1, 1, 32'hDEADBEEF, 1);
    xact(1, 1, 0, 32'h400, 4'hF, 32'h0, 0);

    // Back-to-back chain: read+write is a write, then reads and a halfword store
    exp_stb(1, 1, 8'd2, 4'hF, 32'h12345678); exp_cmp(1, 0, 32'hDEADBEEF, 4);
    xact(1, 1, 1, 32'h8, 4'hF, 32'h12345678, 1);
    exp_stb(1, 0, 8'd2, 4'hF, 32'h0); exp_cmp(1, 0, 32'h12345678, 4);
    xact(1, 1, 0, 32'h8, 4'hF, 32'h0, 1);
    exp_stb(1, 1, 8'd2, 4'hC, 32'hAABBCCDD); exp_cmp(1, 0, 32'h12345678, 4);
    xact(1, 0, 1, 32'h8, 4'hC, 32'hAABBCCDD, 1);
    exp_stb(1, 0, 8'd2, 4'hF, 32'h0); exp_cmp(1, 0, 32'hAABB5678, 4);
    xact(1, 1, 0, 32'h8, 4'hF, 32'h0, 0);

`ifdef ZAP_DMEM_ALIGN_ABORT_EN
    exp_cmp(1, 1, 32'hAABB5678, 1);
    exp_last = 32'hAABB5678;
`else
    exp_stb(1, 0, 8'd4, 4'hF, 32'h0); exp_cmp(1, 0, 32'hDEADBEEF, 4);
    exp_last = 32'hDEADBEEF;
`endif
    xact(1, 1, 0, 32'h12, 4'hF, 32'h0, 0);

    // Flush while waiting: no strobe may appear
    drive(1, 1, 0, 32'h10, 4'hF, 32'h0);
    step(2);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    step(4);
    chk("flush_wait_rd_data", rd_data[1], exp_last);
    exp_stb(1, 0, 8'd2, 4'hF, 32'h0); exp_cmp(1, 0, 32'hAABB5678, 4);
    xact(1, 1, 0, 32'h8, 4'hF, 32'h0, 0);

    // Flush during ACCESS: access still completes and updates read data
    exp_stb(1, 0, 8'd4, 4'hF, 32'h0);
    drive(1, 1, 0, 32'h10, 4'hF, 32'h0);
    step(3);
    rd_en[1] = 1'b0;
    @(negedge clk);
    chk("flush_access_stall", 32'(stall[1]), 32'h0);
    step(1);
    @(negedge clk);
    chk("flush_done_rd_data", rd_data[1], 32'hDEADBEEF);
    step(1);
    @(negedge clk);
    chk("flush_hold_rd_data", rd_data[1], 32'hDEADBEEF);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    step(2);

    // Reset asserted in ACCESS
    drive(1, 1, 0, 32'h8, 4'hF, 32'h0);
    step(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstacc_rd_data1", rd_data[1], 32'h0);
    chk("rstacc_rd_data0", rd_data[0], 32'h0);
    chk("rstacc_sram_en", 32'(sram_en[1]), 32'h0);
    chk("rstacc_sram_addr", 32'(sram_addr[1]), 32'h0);
    chk("rstacc_abort", 32'(abort[1]), 32'h0);
    chk("rstacc_stall", 32'(stall[1]), 32'h1);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    exp_stb(1, 0, 8'd4, 4'hF, 32'h0); exp_cmp(1, 0, 32'hDEADBEEF, 4);
    xact(1, 1, 0, 32'h10, 4'hF, 32'h0, 0);

    step(5);
    chk("cmp_queue_empty", 32'(cq.size()), 32'h0);
    chk("stb_queue_empty", 32'(sq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/zap_dmem_wait_ctrl.md
# zap_dmem_wait_ctrl

Data-side memory controller between the ZAP core's memory-stage data port and a single-port synchronous SRAM. Converts core load/store requests into SRAM accesses with a parameterised number of wait states. Drives the core's `i_data_stall`, `i_data_abort` and `i_rd_data` inputs, and replaces the behavioural data path of the simulation RAM model in synthesisable builds.

## Interface
- `SIZE_IN_BYTES`, 1024: SRAM capacity, a power of two and ≥ 4.
- `WAIT_STATES`, 2: extra wait cycles before each SRAM access, 0..15.
- `i_clk`  in  1: clock; everything is rising-edge.
- `i_reset_n`  in  1: asynchronous, active-low reset.
- `i_read_en`  in  1: core load request; held by the core while stalled.
- `i_write_en`  in  1: core store request; held while stalled.
- `i_address`  in  32: byte address.
- `i_ben`  in  4: byte enables.
- `i_wr_data`  in  32: store data.
- `o_rd_data`  out  32: load data, registered.
- `o_data_stall`  out  1: core must hold the request.
- `o_data_abort`  out  1: access aborted; valid in the completion cycle.
- `o_sram_en`  out  1: SRAM access strobe.
- `o_sram_we`  out  1: SRAM write.
- `o_sram_ben`  out  4: SRAM byte enables.
- `o_sram_addr`  out  $clog2(SIZE_IN_BYTES/4): word address.
- `o_sram_wdata`  out  32: SRAM write data.
- `i_sram_rdata`  in  32: SRAM read data, valid one cycle after `o_sram_en`.

## Operation
- Request: `req = i_read_en | i_write_en`. If both are high, the request is a write.
- Out of range: `i_address >= SIZE_IN_BYTES`.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Request out of range: go to DONE with the abort flag set.
  - Otherwise: go to WAIT (counter loaded with WAIT_STATES-1), or straight to ACCESS if WAIT_STATES = 0.
- WAIT: decrement the counter. Go to ACCESS when the counter reaches 0.
- ACCESS: drive `o_sram_en` = 1 for exactly one cycle, with `o_sram_we`, `o_sram_ben = i_ben`, `o_sram_addr = i_address[..:2]` and `o_sram_wdata`. Always go to DONE.
- DONE:
  - Completed read: register `i_sram_rdata` into `o_rd_data`.
  - Aborted access: `o_data_abort` = 1 and `o_rd_data` is unchanged.
  - Completed write: `o_rd_data` is unchanged.
  - Always go to IDLE next cycle.
- `o_data_stall = req & (state != DONE)`, combinational. The core advances in the DONE cycle.
- `o_data_abort` is high only in DONE and only for an aborted request.
- Request dropped (core flush) while in WAIT: go to IDLE; the SRAM is untouched.
- Request dropped while in ACCESS: the access is not cancelled. DONE is still entered with `o_rd_data` updated, and stall stays low because `req` is 0.
- Back-to-back requests: DONE→IDLE costs one cycle. A new request in IDLE stalls immediately.
- Reset (any cycle, including mid-access):
  - State goes to IDLE and the counter clears.
  - `o_rd_data`, `o_sram_*` and `o_data_abort` all go to 0.
  - `o_data_stall` follows `req`.

## Timing
- Request first seen in IDLE at cycle 0.
- In-range access: ACCESS at cycle W+1, DONE at cycle W+2. Stall is high for W+2 cycles.
- W = 0: stall is high for 2 cycles.
- Aborted access: DONE at cycle 1, stall high for 1 cycle, no SRAM strobe.
- `o_rd_data` becomes valid in the DONE cycle and holds until the next completed read.

## Configuration
- `ZAP_DMEM_ALIGN_ABORT_EN` defined:
  - Word access (`i_ben == 4'hF`) with `i_address[1:0] != 0` aborts.
  - Halfword access (`4'h3`/`4'hC`) with `i_address[0] != 0` aborts.
  - Both abort with the same timing as an out-of-range access.
- Undefined: `i_address[1:0]` is ignored for aborts; the access goes to word address `i_address[..:2]`.

## Structure
- Package `zap_dmem_pkg` holds:
  - FSM state enum with 2-bit encoding: IDLE=0, WAIT=1, ACCESS=2, DONE=3.
  - Counter width constant (4).
  - Abort-reason constants, used for debug only.
- Sub-module `zap_dmem_wait_counter`: a 4-bit loadable down-counter with load, enable and zero flag.

## Test plan
- WAIT_STATES=2, read of 0x10 with SRAM word 4 = 0xDEADBEEF → stall high for 4 cycles; in DONE, `o_rd_data` = 0xDEADBEEF and abort = 0.
- WAIT_STATES=0, write of 0xCAFEF00D to 0x20 with ben 4'hF → one SRAM strobe with addr 8 and we=1; stall high for 2 cycles.
- Read of 0x400 with SIZE 1024 → stall high for 1 cycle, abort=1 in DONE, no SRAM strobe, `o_rd_data` unchanged.
- Request dropped in WAIT → FSM returns to IDLE and `o_sram_en` never asserts. Reset asserted during ACCESS → all outputs 0 and state IDLE.
- Read and write both high at 0x8 → treated as a write (`o_sram_we` = 1).
- With `ZAP_DMEM_ALIGN_ABORT_EN`: word read of 0x12 → abort after 1 cycle. Without the macro: the same read returns SRAM word 4.
